// File: rtl/im_fetch_arbiter.sv
// im_fetch_arbiter
//   Round-robin arbiter sharing one single-port, synchronous-read instruction
//   memory among NUM_C core fetch units. At most one read issues per cycle.
//   Each read carries its owner id down a two-stage valid/id pipeline so the
//   returned word is steered back to that core with a one-cycle rvalid pulse.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   req[NUM_C]      per-core fetch request
//   addr            per-core fetch address, core k at [k*AW +: AW]
//   grant[NUM_C]    pulse: core k's request was issued to memory
//   rvalid[NUM_C]   pulse: rdata slice k holds core k's instruction
//   rdata           per-core returned word, core k at [k*DW +: DW] (held)
//   mem_en/mem_addr memory read request
//   mem_rdata       memory read data, one cycle after mem_en/mem_addr sampled

`ifndef NUM_C
`define NUM_C 4
`endif

module im_fetch_arbiter #(
  parameter int NUM_C = `NUM_C,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_C-1:0]    req,
  input  logic [NUM_C*AW-1:0] addr,
  output logic [NUM_C-1:0]    grant,
  output logic [NUM_C-1:0]    rvalid,
  output logic [NUM_C*DW-1:0] rdata,
  output logic                mem_en,
  output logic [AW-1:0]       mem_addr,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int PW = (NUM_C > 1) ? $clog2(NUM_C) : 1;

  logic [PW-1:0]         ptr_q;
  logic [NUM_C-1:0]      pend_q, grant_q, rvalid_q;
  logic                  mem_en_q;
  logic [AW-1:0]         mem_addr_q;
  logic [NUM_C*DW-1:0]   rdata_q;
  // [0]: issued this cycle (memory samples next edge), [1]: data on mem_rdata
  logic [1:0]            vld_pipe_q;
  logic [1:0][PW-1:0]    id_pipe_q;

  logic [NUM_C-1:0]      elig, gnt_d, clr;
  logic                  found;
  logic [PW-1:0]         win, ptr_d;

  // Scan eligible cores starting at the pointer, wrapping modulo NUM_C.
  always_comb begin
    int idx;
    idx   = 0;
    elig  = req & ~pend_q;
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NUM_C; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= NUM_C) idx = idx - NUM_C;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    ptr_d = (int'(win) == NUM_C - 1) ? '0 : win + PW'(1);
    gnt_d = found ? (NUM_C'(1) << win) : '0;
    clr   = vld_pipe_q[1] ? (NUM_C'(1) << id_pipe_q[1]) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      pend_q     <= '0;
      grant_q    <= '0;
      rvalid_q   <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      grant_q    <= gnt_d;
      mem_en_q   <= found;
      if (found) begin
        mem_addr_q <= addr[int'(win)*AW +: AW];
        ptr_q      <= ptr_d;
      end
      vld_pipe_q <= {vld_pipe_q[0], found};
      id_pipe_q  <= {id_pipe_q[0], win};
      rvalid_q   <= clr;
      if (vld_pipe_q[1]) rdata_q[int'(id_pipe_q[1])*DW +: DW] <= mem_rdata;
      // Returning core is still pending this edge, so it cannot be regranted
      // until the next one; a set and clear never hit the same core.
      pend_q     <= (pend_q & ~clr) | gnt_d;
    end
  end

  assign grant    = grant_q;
  assign rvalid   = rvalid_q;
  assign rdata    = rdata_q;
  assign mem_en   = mem_en_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_im_fetch_arbiter.sv
module tb_im_fetch_arbiter;
  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic [NC-1:0]      req;
  logic [NC*AW-1:0]   addr;
  logic [NC-1:0]      grant, rvalid;
  logic [NC*DW-1:0]   rdata;
  logic               mem_en;
  logic [AW-1:0]      mem_addr;
  logic [DW-1:0]      mem_rdata;

  im_fetch_arbiter #(.NUM_C(NC), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .addr(addr), .grant(grant),
    .rvalid(rvalid), .rdata(rdata), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: word a holds a*2 (word 3 = 0x0006).
  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    return DW'(a * 2);
  endfunction

  // Synchronous-read memory model.
  always @(posedge clk) if (mem_en) mem_rdata <= memf(mem_addr);

  typedef struct {
    int            core;
    logic [DW-1:0] data;
    int            due;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic [NC-1:0]         req;
    logic [NC-1:0][AW-1:0] a;
    logic [7:0][NC-1:0]    g;   // expected grant per edge, g[0] first
  } vec_t;
  vec_t tbl[6];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [AW-1:0]    last_addr;
  logic [NC*DW-1:0] exp_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    @(posedge clk); #1;
    cyc++;
    sbq.delete();
    last_addr = '0;
    exp_rd    = '0;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    rst = 1'b0;
  endtask

  // One clock edge: check arbitration outputs against eg, push the expected
  // return into the scoreboard, and pop any return due at this edge.
  task automatic step(input logic [NC-1:0] eg);
    logic [NC*AW-1:0] a_snap;
    logic [NC-1:0]    exp_rv;
    sb_t              e;
    a_snap = addr;
    @(posedge clk); #1;
    cyc++;
    chk("grant", 64'(grant), 64'(eg));
    chk("mem_en", 64'(mem_en), 64'(|eg));
    for (int k = 0; k < NC; k++) begin
      if (eg[k]) begin
        last_addr = a_snap[k*AW +: AW];
        e.core = k;
        e.data = memf(last_addr);
        e.due  = cyc + 2;
        sbq.push_back(e);
      end
    end
    chk("mem_addr", 64'(mem_addr), 64'(last_addr));
    exp_rv = '0;
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      exp_rv[e.core] = 1'b1;
      exp_rd[e.core*DW +: DW] = e.data;
    end
    chk("rvalid", 64'(rvalid), 64'(exp_rv));
    chk("rdata", 64'(rdata), 64'(exp_rd));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    addr = '0;

    tbl[0].req = 4'b0001; tbl[0].a = {16'd40, 16'd30, 16'd20, 16'd3};  tbl[0].g = 32'h0100_1001;
    tbl[1].req = 4'b1111; tbl[1].a = {16'd40, 16'd30, 16'd20, 16'd10}; tbl[1].g = 32'h8421_8421;
    tbl[2].req = 4'b1001; tbl[2].a = {16'd40, 16'd30, 16'd20, 16'd10}; tbl[2].g = 32'h8108_1081;
    tbl[3].req = 4'b0110; tbl[3].a = {16'd44, 16'd33, 16'd22, 16'd11}; tbl[3].g = 32'h4204_2042;
    tbl[4].req = 4'b0011; tbl[4].a = {16'd40, 16'd30, 16'h1234, 16'h0ABC}; tbl[4].g = 32'h2102_1021;
    tbl[5].req = 4'b0000; tbl[5].a = {16'd40, 16'd30, 16'd20, 16'd10}; tbl[5].g = 32'h0000_0000;

    for (int r = 0; r < 6; r++) begin
      do_reset();
      req  = tbl[r].req;
      addr = tbl[r].a;
      for (int c = 0; c < 8; c++) step(tbl[r].g[c]);
    end

    // Pointer at 2 (after granting core 1), only cores 0 and 3 requesting.
    do_reset();
    addr = {16'd40, 16'd30, 16'd20, 16'd10};
    req  = 4'b0010;
    step(4'b0010);
    req  = 4'b1001;
    step(4'b1000);
    step(4'b0001);
    step(4'b0000);
    req  = 4'b0000;
    step(4'b0000);
    step(4'b0000);

    // Core 1 drops req right after its grant; its read still returns.
    do_reset();
    addr = {16'd40, 16'd30, 16'd21, 16'd7};
    req  = 4'b0011;
    step(4'b0001);
    step(4'b0010);
    req  = 4'b0001;
    addr = {16'd40, 16'd30, 16'hFFFF, 16'd7};
    step(4'b0000);
    step(4'b0001);
    step(4'b0000);
    step(4'b0000);
    step(4'b0001);

    // Idle: in-flight reads drain, then mem_addr and rdata hold.
    req = 4'b0000;
    for (int c = 0; c < 7; c++) step(4'b0000);

    // Reset right after grants to cores 0 and 1 discards both reads.
    do_reset();
    addr = {16'd40, 16'd30, 16'd20, 16'd10};
    req  = 4'b0011;
    step(4'b0001);
    step(4'b0010);
    do_reset();
    req  = 4'b0110;
    step(4'b0010);
    step(4'b0100);
    req  = 4'b0000;
    for (int c = 0; c < 4; c++) step(4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
